// File: rtl/snn_dec_pkg.sv
// snn_dec_pkg: shared defaults, handshake state type and saturation helpers for the spike rate decoder
package snn_dec_pkg;

    localparam int WIN_LEN_DEF = 1024;
    localparam int CNT_W_DEF   = 10;
    localparam int PWM_W_DEF   = 8;

    // Largest value representable in a w-bit unsigned counter
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max(CNT_W_DEF);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hs_state_t;

endpackage

// File: rtl/spike_pwm.sv
// spike_pwm: per-channel duty register and comparator driven by a shared free-running PWM counter
module spike_pwm
    import snn_dec_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PWM_W = PWM_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [PWM_W-1:0] i_p,
    input  logic [CNT_W-1:0] i_rate,
    output logic             o_pwm
);

    localparam int PMAX = cnt_max(PWM_W);

    logic [PWM_W-1:0] r_duty;
    logic [PWM_W-1:0] w_duty;
    logic             w_wrap;

    assign w_duty = (32'(i_rate) > PMAX) ? '1 : PWM_W'(i_rate);
    assign w_wrap = (i_p == '1);

    // Duty only reloads as the counter wraps, so every period is whole
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_duty <= '0;
            o_pwm  <= 1'b0;
        end else begin
            if (w_wrap)
                r_duty <= w_duty;
            o_pwm <= (i_p < r_duty);
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed spike-rate counter with valid/ready output; PWM drive under SPIKE_DEC_PWM_EN
module spike_rate_decoder
    import snn_dec_pkg::*;
#(
    parameter int EXCNUM  = 2,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int PWM_W   = PWM_W_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [EXCNUM-1:0]       i_spike_in,
    output logic [EXCNUM*CNT_W-1:0] o_rate_data,
    output logic                    o_rate_valid,
    input  logic                    i_rate_ready,
    output logic                    o_overrun,
    output logic                    o_window_tick,
    output logic [EXCNUM-1:0]       o_pwm_out
);

    localparam int              WC_W     = $clog2(WIN_LEN);
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] ACC_MAX = CNT_W'(cnt_max(CNT_W));

    if (WIN_LEN < 2 || PWM_W < 1) begin : g_bad_cfg
        $error("spike_rate_decoder: WIN_LEN must be >= 2 and PWM_W >= 1");
    end

    logic [WC_W-1:0]         r_win;
    logic [EXCNUM-1:0]       r_prev;
    logic [EXCNUM*CNT_W-1:0] r_acc;
    hs_state_t               r_state;
    logic [EXCNUM-1:0]       w_edge;
    logic [EXCNUM*CNT_W-1:0] w_sum;
    logic                    w_close;

    assign w_edge       = i_spike_in & ~r_prev;
    assign w_close      = i_en && (r_win == WIN_LAST);
    assign o_rate_valid = (r_state == FULL);

    for (genvar c = 0; c < EXCNUM; c++) begin : g_ch
        logic [CNT_W-1:0] w_acc;
        assign w_acc = r_acc[c*CNT_W +: CNT_W];
        assign w_sum[c*CNT_W +: CNT_W] = (w_edge[c] && w_acc != ACC_MAX) ? w_acc + 1'b1 : w_acc;
    end

    // Window position, edge history and accumulators advance only on enabled cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_win  <= '0;
            r_prev <= '0;
            r_acc  <= '0;
        end else if (i_en) begin
            r_prev <= i_spike_in;
            r_win  <= w_close ? '0 : r_win + 1'b1;
            r_acc  <= w_close ? '0 : w_sum;
        end
    end

    // Output handshake: a close always wins and refills, a transfer empties otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= EMPTY;
            o_rate_data   <= '0;
            o_overrun     <= 1'b0;
            o_window_tick <= 1'b0;
        end else begin
            o_window_tick <= w_close;
            if (w_close) begin
                o_rate_data <= w_sum;
                r_state     <= FULL;
                if (r_state == FULL && !i_rate_ready)
                    o_overrun <= 1'b1;
            end else if (r_state == FULL && i_rate_ready) begin
                r_state <= EMPTY;
            end
        end
    end

`ifdef SPIKE_DEC_PWM_EN
    logic [PWM_W-1:0] r_p;

    // Free-running PWM phase shared by all channels, unaffected by enable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_p <= '0;
        else
            r_p <= r_p + 1'b1;
    end

    for (genvar c = 0; c < EXCNUM; c++) begin : g_pwm
        spike_pwm #(
            .CNT_W(CNT_W),
            .PWM_W(PWM_W)
        ) u_pwm (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_p    (r_p),
            .i_rate (o_rate_data[c*CNT_W +: CNT_W]),
            .o_pwm  (o_pwm_out[c])
        );
    end
`else
    assign o_pwm_out = '0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: scoreboard bench for the spike rate decoder (CNT_W=4 main, CNT_W=3 saturation instance)
module tb_spike_rate_decoder;

`ifdef SPIKE_DEC_PWM_EN
    localparam bit PWM_ON = 1'b1;
`else
    localparam bit PWM_ON = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       en    = 1'b0;
    logic       rdy   = 1'b0;
    logic [1:0] spk   = 2'b00;
    logic [7:0] data;
    logic       valid, ovr, tick;
    logic [1:0] pwm;
    logic [5:0] s_data;
    logic       s_valid, s_ovr, s_tick;
    logic [1:0] s_pwm;
    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];

    always #5 clk = ~clk;

    spike_rate_decoder #(.EXCNUM(2), .WIN_LEN(16), .CNT_W(4), .PWM_W(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_spike_in(spk),
        .o_rate_data(data), .o_rate_valid(valid), .i_rate_ready(rdy),
        .o_overrun(ovr), .o_window_tick(tick), .o_pwm_out(pwm)
    );

    spike_rate_decoder #(.EXCNUM(2), .WIN_LEN(16), .CNT_W(3), .PWM_W(3)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_spike_in(spk),
        .o_rate_data(s_data), .o_rate_valid(s_valid), .i_rate_ready(rdy),
        .o_overrun(s_ovr), .o_window_tick(s_tick), .o_pwm_out(s_pwm)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Every accepted transfer is matched against the oldest expected window
    always @(negedge clk) begin
        if (rst_n && valid && rdy) begin
            if (sb_q.size() == 0)
                check("sb_empty", 1, 0);
            else
                check("rate_data", data, sb_q.pop_front());
        end
    end

    task automatic win(input int n, input bit last, input logic [19:0] s0, input logic [19:0] s1,
                       input logic [19:0] r, input logic [19:0] e, output int p0, output int p1);
        p0 = 0;
        p1 = 0;
        for (int j = 0; j < n; j++) begin
            spk = {s1[j], s0[j]};
            rdy = r[j];
            en  = e[j];
            @(posedge clk);
            #1;
            check("window_tick", tick, last && j == n - 1);
            check("sat_window_tick", s_tick, last && j == n - 1);
            if (j >= n - 8) begin
                p0 += int'(pwm[0]);
                p1 += int'(pwm[1]);
            end
        end
    endtask

    initial begin
        int p0, p1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (5) begin
            spk = ~spk;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        spk   = 2'b01;
        #1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", ovr, 0);
        check("rst_tick", tick, 0);
        check("rst_pwm", pwm, 0);
        check("rst_sat_pwm", s_pwm, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_valid", valid, 0);
        rst_n = 1'b1;
        spk   = 2'b00;

        sb_q.push_back(8'h00);
        win(16, 1, 20'h0, 20'h0, 20'h0, 20'hFFFFF, p0, p1);
        check("idle_valid", valid, 1);
        check("idle_data", data, 8'h00);

        sb_q.push_back(8'h15);
        win(1, 0, 20'h0, 20'h0, 20'hFFFFF, 20'hFFFFF, p0, p1);
        check("accept_valid_fall", valid, 0);
        win(15, 1, 20'h00155, 20'h0001E, 20'hFFFFF, 20'hFFFFF, p0, p1);
        check("count_valid", valid, 1);

        sb_q.push_back(8'h08);
        win(16, 1, 20'h0AAAA, 20'h0, 20'hFFFFF, 20'hFFFFF, p0, p1);
        check("pwm_b_ch0", p0, PWM_ON ? 5 : 0);
        check("pwm_b_ch1", p1, PWM_ON ? 1 : 0);
        check("toggle_data", data, 8'h08);
        check("sat_data", s_data, 6'h07);

        sb_q.push_back(8'h01);
        win(16, 1, 20'h00008, 20'h0, 20'hFFFFF, 20'hFFFFF, p0, p1);
        check("pwm_clamp_ch0", p0, PWM_ON ? 7 : 0);
        check("pwm_clamp_ch1", p1, 0);
        check("sat_restart_data", s_data, 6'h01);

        win(16, 1, 20'h0, 20'h00044, 20'h08000, 20'hFFFFF, p0, p1);
        check("simul_valid", valid, 1);
        check("simul_overrun", ovr, 0);
        check("simul_data", data, 8'h20);

        win(16, 1, 20'h00012, 20'h00080, 20'h0, 20'hFFFFF, p0, p1);
        check("ovr1_overrun", ovr, 1);
        check("ovr1_valid", valid, 1);
        check("ovr1_data", data, 8'h12);

        sb_q.push_back(8'h03);
        win(16, 1, 20'h00224, 20'h0, 20'h0, 20'hFFFFF, p0, p1);
        check("ovr2_data", data, 8'h03);
        check("ovr2_valid", valid, 1);

        sb_q.push_back(8'h10);
        win(16, 1, 20'h0, 20'h00008, 20'hFFFFF, 20'hFFFFF, p0, p1);
        check("pwm_rate3_ch0", p0, PWM_ON ? 3 : 0);
        check("pwm_rate3_ch1", p1, 0);
        check("ovr_sticky", ovr, 1);

        sb_q.push_back(8'h02);
        win(20, 1, 20'h00442, 20'h0, 20'hFFFFF, 20'hFFFF0, p0, p1);
        check("en_gap_data", data, 8'h02);

        spk = 2'b00;
        rdy = 1'b1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        check("final_valid", valid, 0);
        check("final_overrun", ovr, 1);
        check("final_sat_valid", s_valid, 0);
        check("final_sat_overrun", s_ovr, 1);
        check("sb_left", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
